// File: rtl/ext_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ext_pipe_pkg
// Shared constants for the pipelined immediate/load extender.
//   MODE_W   : width of the operation-select field
//   mode_e   : the eight operation encodings (3-bit successors of the old
//              Ext_Zero / Ext_Sign / Ext_High selects, plus the load modes)
//   helpers  : small decode functions used by the datapath
// -----------------------------------------------------------------------------
package ext_pipe_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_ZERO = 3'b000,
      MODE_SIGN = 3'b001,
      MODE_HIGH = 3'b010,
      MODE_RSVD = 3'b011,
      MODE_LBU  = 3'b100,
      MODE_LB   = 3'b101,
      MODE_LHU  = 3'b110,
      MODE_LH   = 3'b111
   } mode_e;

   // Halfword loads are the only modes with an alignment constraint.
   function automatic logic mode_is_half(input mode_e m);
      return (m == MODE_LHU) || (m == MODE_LH);
   endfunction

   // Signed variants of the load modes carry a 1 in the LSB of the encoding.
   function automatic logic mode_is_signed_load(input mode_e m);
      return (m == MODE_LB) || (m == MODE_LH);
   endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// -----------------------------------------------------------------------------
// ext_pipe_if
// Valid/ready bundle around the extender.
//   in_*  : producer side (item, mode, byte offset, tag) with in_ready back
//   out_* : consumer side (result, tag, error) with out_ready back
// Modports:
//   master : the producer/consumer environment that talks to the block
//   slave  : the ext_pipe block itself
// -----------------------------------------------------------------------------
interface ext_pipe_if
   import ext_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5,
   parameter int OFF_W  = $clog2(DATA_W/8)
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [MODE_W-1:0] in_mode;
   logic [OFF_W-1:0]  in_offset;
   logic [TAG_W-1:0]  in_tag;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [TAG_W-1:0]  out_tag;
   logic              out_err;

   modport master (
      output in_valid, in_data, in_mode, in_offset, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_err
   );

   modport slave (
      input  in_valid, in_data, in_mode, in_offset, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_err
   );

endinterface

// File: rtl/ext_pipe_core.sv
// -----------------------------------------------------------------------------
// ext_pipe_core
// Purely combinational extender shared by immediates and load data.
//   mode   in  MODE_W  operation select (see mode_e)
//   data   in  DATA_W  immediate in the low IMM_W bits, or raw load word
//   offset in  OFF_W   little-endian byte offset, load modes only
//   result out DATA_W  extended value (0 on error)
//   err    out 1       reserved mode or odd offset on a halfword load
// -----------------------------------------------------------------------------
module ext_pipe_core
   import ext_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic [MODE_W-1:0] mode,
   input  logic [DATA_W-1:0] data,
   input  logic [OFF_W-1:0]  offset,
   output logic [DATA_W-1:0] result,
   output logic              err
);

   mode_e             mode_s;
   logic [IMM_W-1:0]  imm_s;
   logic [OFF_W-1:0]  half_off_s;
   logic [7:0]        byte_s;
   logic [15:0]       half_s;

   assign mode_s = mode_e'(mode);
   assign imm_s  = data[IMM_W-1:0];

   // Force the halfword offset even so the part-select never leaves the word;
   // odd offsets are flagged as errors below and their data is discarded.
   always_comb begin
      half_off_s    = offset;
      half_off_s[0] = 1'b0;
   end

   assign byte_s = data[{offset, 3'b000} +: 8];
   assign half_s = data[{half_off_s, 3'b000} +: 16];

   // Result select: fill the whole word first, then overlay the low field.
   // This keeps the code legal for IMM_W == DATA_W (no zero-width repeats).
   always_comb begin
      result = {DATA_W{1'b0}};
      err    = 1'b0;
      case (mode_s)
         MODE_ZERO: begin
            result[IMM_W-1:0] = imm_s;
         end
         MODE_SIGN: begin
            result            = {DATA_W{imm_s[IMM_W-1]}};
            result[IMM_W-1:0] = imm_s;
         end
         MODE_HIGH: begin
            result[DATA_W-1 -: IMM_W] = imm_s;
         end
         MODE_LBU, MODE_LB: begin
            if (mode_is_signed_load(mode_s)) begin
               result = {DATA_W{byte_s[7]}};
            end else begin
               result = {DATA_W{1'b0}};
            end
            result[7:0] = byte_s;
         end
         MODE_LHU, MODE_LH: begin
            if (mode_is_half(mode_s) && offset[0]) begin
               result = {DATA_W{1'b0}};
               err    = 1'b1;
            end else if (mode_is_signed_load(mode_s)) begin
               result       = {DATA_W{half_s[15]}};
               result[15:0] = half_s;
            end else begin
               result[15:0] = half_s;
            end
         end
         MODE_RSVD: begin
            result = {DATA_W{1'b0}};
            err    = 1'b1;
         end
         default: begin
            result = {DATA_W{1'b0}};
            err    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// -----------------------------------------------------------------------------
// ext_pipe
// Pipelined immediate/load extender with a registered output stage (OUT) and
// one skid entry (SKID). The result is computed on the input side and captured
// at the accept edge; OUT drives the consumer directly and in_ready is simply
// the inverse of SKID's valid bit, so there is no combinational path from
// out_ready to in_ready.
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   flush    in   synchronous flush of both entries (wins over accept/drain)
//   bus      slave modport of ext_pipe_if (in_* / out_* handshake)
// -----------------------------------------------------------------------------
module ext_pipe
   import ext_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int TAG_W  = 5,
   parameter int OFF_W  = $clog2(DATA_W/8)
) (
   input logic       clk,
   input logic       reset_n,
   input logic       flush,
   ext_pipe_if.slave bus
);

   logic [DATA_W-1:0] core_data_s;
   logic              core_err_s;
   logic              accept_s;
   logic              drain_s;

   logic              out_valid_r;
   logic [DATA_W-1:0] out_data_r;
   logic [TAG_W-1:0]  out_tag_r;
   logic              out_err_r;

   logic              skid_valid_r;
   logic [DATA_W-1:0] skid_data_r;
   logic [TAG_W-1:0]  skid_tag_r;
   logic              skid_err_r;

   ext_pipe_core #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W),
      .OFF_W  (OFF_W)
   ) u_core (
      .mode   (bus.in_mode),
      .data   (bus.in_data),
      .offset (bus.in_offset),
      .result (core_data_s),
      .err    (core_err_s)
   );

   assign accept_s = bus.in_valid & ~skid_valid_r;
   assign drain_s  = out_valid_r & bus.out_ready;

   assign bus.in_ready  = ~skid_valid_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_tag   = out_tag_r;
   assign bus.out_err   = out_err_r;

   // Two-entry OUT/SKID storage; data fields are left untouched when an entry
   // empties so out_data/out_tag hold their last value while out_valid is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_r  <= 1'b0;
         out_data_r   <= {DATA_W{1'b0}};
         out_tag_r    <= {TAG_W{1'b0}};
         out_err_r    <= 1'b0;
         skid_valid_r <= 1'b0;
         skid_data_r  <= {DATA_W{1'b0}};
         skid_tag_r   <= {TAG_W{1'b0}};
         skid_err_r   <= 1'b0;
      end else if (flush) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (!out_valid_r) begin
         // SKID is never occupied while OUT is empty.
         if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= core_data_s;
            out_tag_r   <= bus.in_tag;
            out_err_r   <= core_err_s;
         end else begin
            out_valid_r <= 1'b0;
         end
      end else if (drain_s) begin
         if (skid_valid_r) begin
            out_data_r   <= skid_data_r;
            out_tag_r    <= skid_tag_r;
            out_err_r    <= skid_err_r;
            skid_valid_r <= 1'b0;
         end else if (accept_s) begin
            out_data_r <= core_data_s;
            out_tag_r  <= bus.in_tag;
            out_err_r  <= core_err_s;
         end else begin
            out_valid_r <= 1'b0;
         end
      end else if (accept_s) begin
         // OUT stalled: park the new item; in_ready drops next cycle.
         skid_valid_r <= 1'b1;
         skid_data_r  <= core_data_s;
         skid_tag_r   <= bus.in_tag;
         skid_err_r   <= core_err_s;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

endmodule

// File: tb/tb_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_ext_pipe
// Self-checking bench for ext_pipe: directed steps plus randomized traffic,
// checked against an arithmetic reference model and an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_ext_pipe;
   import ext_pipe_pkg::*;

   localparam int DW = 32;
   localparam int TW = 5;
   localparam int OW = 2;

   typedef struct {
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
      logic          err;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic flush;
   int   test_cnt = 0;
   int   fail_cnt = 0;
   int   drained  = 0;
   exp_t sb_q[$];

   ext_pipe_if #(.DATA_W(DW), .TAG_W(TW), .OFF_W(OW)) bus ();

   ext_pipe #(.DATA_W(DW), .IMM_W(16), .TAG_W(TW), .OFF_W(OW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference: extension rules expressed with plain integer arithmetic.
   function automatic void ref_model(input logic [2:0] mode, input logic [31:0] data,
                                     input logic [1:0] off, output logic [31:0] res,
                                     output logic err);
      int unsigned d, imm, sh, b, h;
      d   = data;
      imm = d % 65536;
      sh  = 32'd1 << (8 * int'(off));
      b   = (d / sh) % 256;
      h   = (d / sh) % 65536;
      res = 32'd0;
      err = 1'b0;
      case (mode)
         3'd0: res = imm;
         3'd1: res = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
         3'd2: res = imm * 65536;
         3'd4: res = b;
         3'd5: res = (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd6: if (off % 2 == 1) err = 1'b1; else res = h;
         3'd7: if (off % 2 == 1) err = 1'b1; else res = (h >= 32768) ? h + 32'hFFFF_0000 : h;
         default: err = 1'b1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] d,
                        input logic [1:0] o, input logic [4:0] t);
      bus.in_valid  = v;
      bus.in_mode   = m;
      bus.in_data   = d;
      bus.in_offset = o;
      bus.in_tag    = t;
   endtask

   // One clock: sample at the falling edge (scoreboard), return 1 after rising.
   task automatic cycle();
      exp_t e;
      logic [31:0] r;
      logic er;
      @(negedge clk);
      if (reset_n) begin
         if (flush) begin
            sb_q.delete();
         end else begin
            if (bus.out_valid && bus.out_ready) begin
               check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  check("sb_data", bus.out_data, e.data);
                  check("sb_tag", 32'(bus.out_tag), 32'(e.tag));
                  check("sb_err", 32'(bus.out_err), 32'(e.err));
               end
               drained++;
            end
            if (bus.in_valid && bus.in_ready) begin
               ref_model(bus.in_mode, bus.in_data, bus.in_offset, r, er);
               e.data = r;
               e.tag  = bus.in_tag;
               e.err  = er;
               sb_q.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic single(input string nm, input logic [2:0] m, input logic [31:0] d,
                         input logic [1:0] o, input logic [4:0] t,
                         input logic [31:0] exp_d, input logic exp_e);
      drive(1'b1, m, d, o, t);
      cycle();
      drive(1'b0, 3'd0, 32'd0, 2'd0, 5'd0);
      check({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({nm, "_data"}, bus.out_data, exp_d);
      check({nm, "_err"}, 32'(bus.out_err), 32'(exp_e));
      cycle();
      check({nm, "_hold"}, bus.out_data, exp_d);
   endtask

   initial begin
      int d0;
      logic [31:0] held;

      // Reset state
      reset_n       = 1'b0;
      flush         = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 3'd0, 32'd0, 2'd0, 5'd0);
      #3;
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      check("rst_tag", 32'(bus.out_tag), 32'd0);
      check("rst_err", 32'(bus.out_err), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Immediates
      single("sign", 3'd1, 32'h0000_8001, 2'd0, 5'd1, 32'hFFFF_8001, 1'b0);
      single("zero", 3'd0, 32'h0000_8001, 2'd0, 5'd2, 32'h0000_8001, 1'b0);
      single("high", 3'd2, 32'h0000_1234, 2'd0, 5'd3, 32'h1234_0000, 1'b0);
      single("rsvd", 3'd3, 32'h1234_5678, 2'd1, 5'd4, 32'h0000_0000, 1'b1);

      // Loads on 0x80FF_7F01 (bytes LE: 01, 7F, FF, 80)
      single("lb0",  3'd5, 32'h80FF_7F01, 2'd0, 5'd5, 32'h0000_0001, 1'b0);
      single("lb3",  3'd5, 32'h80FF_7F01, 2'd3, 5'd6, 32'hFFFF_FF80, 1'b0);
      single("lbu1", 3'd4, 32'h80FF_7F01, 2'd1, 5'd7, 32'h0000_007F, 1'b0);
      single("lbu2", 3'd4, 32'h80FF_7F01, 2'd2, 5'd8, 32'h0000_00FF, 1'b0);
      single("lh2",  3'd7, 32'h80FF_7F01, 2'd2, 5'd9, 32'hFFFF_80FF, 1'b0);
      single("lhu0", 3'd6, 32'h80FF_7F01, 2'd0, 5'd10, 32'h0000_7F01, 1'b0);
      single("lh1",  3'd7, 32'h80FF_7F01, 2'd1, 5'd11, 32'h0000_0000, 1'b1);

      // Back-pressure: tags 1,2 accepted, 3 waits
      d0 = drained;
      bus.out_ready = 1'b0;
      drive(1'b1, 3'd1, 32'h0000_0011, 2'd0, 5'd1);
      cycle();
      drive(1'b1, 3'd0, 32'h0000_0022, 2'd0, 5'd2);
      check("bp_ready1", 32'(bus.in_ready), 32'd1);
      cycle();
      drive(1'b1, 3'd2, 32'h0000_0033, 2'd0, 5'd3);
      check("bp_ready0", 32'(bus.in_ready), 32'd0);
      check("bp_tag1", 32'(bus.out_tag), 32'd1);
      held = bus.out_data;
      cycle();
      cycle();
      check("bp_stable_tag", 32'(bus.out_tag), 32'd1);
      check("bp_stable_data", bus.out_data, held);
      check("bp_still_full", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      cycle();
      check("bp_tag2", 32'(bus.out_tag), 32'd2);
      check("bp_ready_back", 32'(bus.in_ready), 32'd1);
      cycle();
      drive(1'b0, 3'd0, 32'd0, 2'd0, 5'd0);
      check("bp_tag3", 32'(bus.out_tag), 32'd3);
      check("bp_data3", bus.out_data, 32'h0033_0000);
      cycle();
      check("bp_empty", 32'(bus.out_valid), 32'd0);
      check("bp_count", 32'(drained - d0), 32'd3);

      // Streaming 16 items
      d0 = drained;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 3'($urandom_range(7)), $urandom, 2'($urandom_range(3)), 5'(i));
         if (i > 0) check("st_valid", 32'(bus.out_valid), 32'd1);
         check("st_ready", 32'(bus.in_ready), 32'd1);
         cycle();
      end
      drive(1'b0, 3'd0, 32'd0, 2'd0, 5'd0);
      check("st_last_tag", 32'(bus.out_tag), 32'd15);
      cycle();
      check("st_count", 32'(drained - d0), 32'd16);
      check("st_sb_empty", 32'(sb_q.size()), 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
               2'($urandom_range(3)), 5'($urandom_range(31)));
         bus.out_ready = ($urandom_range(3) != 0);
         cycle();
      end
      drive(1'b0, 3'd0, 32'd0, 2'd0, 5'd0);
      bus.out_ready = 1'b1;
      cycle();
      cycle();
      cycle();
      check("rnd_sb_empty", 32'(sb_q.size()), 32'd0);
      check("rnd_idle", 32'(bus.out_valid), 32'd0);

      // Flush with both entries full
      bus.out_ready = 1'b0;
      drive(1'b1, 3'd1, 32'h0000_0007, 2'd0, 5'd7);
      cycle();
      drive(1'b1, 3'd1, 32'h0000_0008, 2'd0, 5'd8);
      cycle();
      check("fl_full", 32'(bus.in_ready), 32'd0);
      flush = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b1, 3'd1, 32'h0000_0009, 2'd0, 5'd9);
      cycle();
      flush = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 2'd0, 5'd0);
      check("fl_valid", 32'(bus.out_valid), 32'd0);
      check("fl_ready", 32'(bus.in_ready), 32'd1);
      d0 = drained;
      cycle();
      cycle();
      check("fl_no_emit", 32'(drained - d0), 32'd0);
      check("fl_still_empty", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset between edges with both entries full
      bus.out_ready = 1'b0;
      drive(1'b1, 3'd0, 32'h0000_00AA, 2'd0, 5'd10);
      cycle();
      drive(1'b1, 3'd0, 32'h0000_00BB, 2'd0, 5'd11);
      cycle();
      drive(1'b0, 3'd0, 32'd0, 2'd0, 5'd0);
      check("ar_pre_valid", 32'(bus.out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_valid", 32'(bus.out_valid), 32'd0);
      check("ar_data", bus.out_data, 32'd0);
      check("ar_tag", 32'(bus.out_tag), 32'd0);
      check("ar_ready", 32'(bus.in_ready), 32'd1);
      sb_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      single("post_rst", 3'd1, 32'h0000_FFFF, 2'd0, 5'd12, 32'hFFFF_FFFF, 1'b0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
